// File: rtl/bsg_fifo_to_dfi.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fifo_to_dfi
// Brief    : Replays packed command/write streams onto a DFI 1x interface and
//            buffers returned read data into a valid/ready stream.
// Revision : 1.0
// ============================================================================
module bsg_fifo_to_dfi #(
    parameter  int dq_data_width_p = 32,
    parameter  int wr_latency_p    = 2,
    parameter  int rd_latency_p    = 4,
    parameter  int burst_cycles_p  = 2,
    parameter  int rd_fifo_els_p   = 8,
    localparam int dq_group_lp     = dq_data_width_p >> 3
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic                                       cmd_v_i,
    input  logic [25:0]                                cmd_data_i,
    output logic                                       cmd_yumi_o,
    input  logic                                       wr_v_i,
    input  logic [2*dq_data_width_p+2*dq_group_lp-1:0] wr_data_i,
    output logic                                       wr_yumi_o,
    output logic                                       rd_v_o,
    output logic [2*dq_data_width_p-1:0]               rd_data_o,
    input  logic                                       rd_ready_i,
    output logic [2:0]                                 dfi_bank_o,
    output logic [15:0]                                dfi_address_o,
    output logic                                       dfi_cke_o,
    output logic                                       dfi_cs_n_o,
    output logic                                       dfi_ras_n_o,
    output logic                                       dfi_cas_n_o,
    output logic                                       dfi_we_n_o,
    output logic                                       dfi_reset_n_o,
    output logic                                       dfi_odt_o,
    output logic                                       dfi_wrdata_en_o,
    output logic [2*dq_data_width_p-1:0]               dfi_wrdata_o,
    output logic [2*dq_group_lp-1:0]                   dfi_wrdata_mask_o,
    output logic                                       dfi_rddata_en_o,
    input  logic [2*dq_data_width_p-1:0]               dfi_rddata_i,
    input  logic                                       dfi_rddata_valid_i,
    output logic                                       error_o
);

    localparam int WR_SCHED_W = wr_latency_p + burst_cycles_p;
    localparam int RD_SCHED_W = rd_latency_p + burst_cycles_p;
    localparam int PTR_W      = $clog2(rd_fifo_els_p);
    localparam int CNT_W      = PTR_W + 1;
    localparam int GAP_W      = $clog2(burst_cycles_p) + 1;
    localparam int RD_W       = 2*dq_data_width_p;
    localparam int MASK_W     = 2*dq_group_lp;

    localparam logic [25:0] CMD_RESET = {3'b000, 16'h0000, 1'b0, 4'b1111, 2'b00};
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(burst_cycles_p - 1);
    localparam logic [CNT_W-1:0] RES_BURST = CNT_W'(burst_cycles_p);

    // Schedules are loaded one slot short of the latency: the cycle after issue
    // is the pin cycle, and bit 0 means "pull data now, assert enable next".
    localparam logic [WR_SCHED_W-1:0] WR_BURST =
        {{(WR_SCHED_W-burst_cycles_p){1'b0}}, {burst_cycles_p{1'b1}}} << (wr_latency_p - 1);
    localparam logic [RD_SCHED_W-1:0] RD_BURST =
        {{(RD_SCHED_W-burst_cycles_p){1'b0}}, {burst_cycles_p{1'b1}}} << (rd_latency_p - 1);

    logic [25:0]             dfi_cmd_q,     dfi_cmd_d;
    logic [WR_SCHED_W-1:0]   wr_sched_q,    wr_sched_d;
    logic [RD_SCHED_W-1:0]   rd_sched_q,    rd_sched_d;
    logic [GAP_W-1:0]        gap_q,         gap_d;
    logic                    wrdata_en_q,   wrdata_en_d;
    logic [RD_W-1:0]         wrdata_q,      wrdata_d;
    logic [MASK_W-1:0]       wrmask_q,      wrmask_d;
    logic                    rddata_en_q,   rddata_en_d;
    logic [CNT_W-1:0]        res_q,         res_d;
    logic [CNT_W-1:0]        cnt_q,         cnt_d;
    logic [PTR_W-1:0]        wptr_q,        wptr_d;
    logic [PTR_W-1:0]        rptr_q,        rptr_d;
    logic                    err_q,         err_d;
    logic [RD_W-1:0]         mem_q [rd_fifo_els_p];

    logic                    w_is_cas;
    logic                    w_is_wr;
    logic                    w_is_rd;
    logic                    w_gap_zero;
    logic [CNT_W:0]          w_rd_free;
    logic                    w_ok;
    logic                    w_issue_wr;
    logic                    w_issue_rd;
    logic                    w_wr_pull;
    logic                    w_rel;
    logic                    w_deq;

    assign w_is_cas   = ~cmd_data_i[5] & cmd_data_i[4] & ~cmd_data_i[3];
    assign w_is_wr    = w_is_cas & ~cmd_data_i[2];
    assign w_is_rd    = w_is_cas &  cmd_data_i[2];
    assign w_gap_zero = (gap_q == '0);
    assign w_rd_free  = (CNT_W+1)'(rd_fifo_els_p) - ({1'b0, cnt_q} + {1'b0, res_q});
    assign w_ok       = w_is_wr ? w_gap_zero
                      : w_is_rd ? (w_gap_zero & (w_rd_free >= (CNT_W+1)'(burst_cycles_p)))
                      : 1'b1;

    assign cmd_yumi_o = cmd_v_i & w_ok;
    assign w_issue_wr = cmd_yumi_o & w_is_wr;
    assign w_issue_rd = cmd_yumi_o & w_is_rd;
    assign w_wr_pull  = wr_sched_q[0];
    assign wr_yumi_o  = w_wr_pull & wr_v_i;
    assign w_rel      = dfi_rddata_valid_i & (res_q != '0);
    assign rd_v_o     = (cnt_q != '0);
    assign w_deq      = rd_v_o & rd_ready_i;
    assign rd_data_o  = mem_q[rptr_q];

    always_comb begin
        dfi_cmd_d = {dfi_cmd_q[25:6], 4'b1111, dfi_cmd_q[1:0]};
        if (cmd_yumi_o) begin
            dfi_cmd_d = cmd_data_i;
        end

        gap_d = w_gap_zero ? gap_q : gap_q - GAP_W'(1);
        if (w_issue_wr | w_issue_rd) begin
            gap_d = GAP_LOAD;
        end

        wr_sched_d  = (wr_sched_q >> 1) | (w_issue_wr ? WR_BURST : '0);
        rd_sched_d  = (rd_sched_q >> 1) | (w_issue_rd ? RD_BURST : '0);
        wrdata_en_d = w_wr_pull;
        rddata_en_d = rd_sched_q[0];

        // A missing write beat is replaced by zeros so the burst keeps its shape.
        wrdata_d = wrdata_q;
        wrmask_d = wrmask_q;
        if (w_wr_pull) begin
            wrdata_d = wr_v_i ? wr_data_i[RD_W+MASK_W-1:MASK_W] : '0;
            wrmask_d = wr_v_i ? wr_data_i[MASK_W-1:0]           : '0;
        end

        res_d = res_q + (w_issue_rd ? RES_BURST : '0) - CNT_W'(w_rel);
        cnt_d  = cnt_q + CNT_W'(w_rel) - CNT_W'(w_deq);
        wptr_d = wptr_q + PTR_W'(w_rel);
        rptr_d = rptr_q + PTR_W'(w_deq);

        err_d = err_q | (w_wr_pull & ~wr_v_i) | (dfi_rddata_valid_i & (res_q == '0));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dfi_cmd_q   <= CMD_RESET;
            wr_sched_q  <= '0;
            rd_sched_q  <= '0;
            gap_q       <= '0;
            wrdata_en_q <= 1'b0;
            wrdata_q    <= '0;
            wrmask_q    <= '0;
            rddata_en_q <= 1'b0;
            res_q       <= '0;
            cnt_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            dfi_cmd_q   <= dfi_cmd_d;
            wr_sched_q  <= wr_sched_d;
            rd_sched_q  <= rd_sched_d;
            gap_q       <= gap_d;
            wrdata_en_q <= wrdata_en_d;
            wrdata_q    <= wrdata_d;
            wrmask_q    <= wrmask_d;
            rddata_en_q <= rddata_en_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            err_q       <= err_d;
        end
    end

    // Storage only; occupancy and pointers carry the reset state.
    always_ff @(posedge clk_i) begin
        if (w_rel) begin
            mem_q[wptr_q] <= dfi_rddata_i;
        end
    end

    assign {dfi_bank_o, dfi_address_o, dfi_cke_o, dfi_cs_n_o, dfi_ras_n_o,
            dfi_cas_n_o, dfi_we_n_o, dfi_reset_n_o, dfi_odt_o} = dfi_cmd_q;
    assign dfi_wrdata_en_o   = wrdata_en_q;
    assign dfi_wrdata_o      = wrdata_q;
    assign dfi_wrdata_mask_o = wrmask_q;
    assign dfi_rddata_en_o   = rddata_en_q;
    assign error_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_fifo_to_dfi.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_fifo_to_dfi
// Brief    : Randomized scoreboard bench for bsg_fifo_to_dfi.
// Revision : 1.0
// ============================================================================
module tb_bsg_fifo_to_dfi;

    localparam int DQ      = 32;
    localparam int GRP     = DQ >> 3;
    localparam int WL      = 2;
    localparam int RL      = 4;
    localparam int BC      = 2;
    localparam int ELS     = 8;
    localparam int PHY_LAT = 3;
    localparam int WRW     = 2*DQ + 2*GRP;
    localparam int RDW     = 2*DQ;

    localparam logic [6:0] CTL_RD  = 7'b1_0101_1_0;
    localparam logic [6:0] CTL_WR  = 7'b1_0100_1_0;
    localparam logic [6:0] CTL_ACT = 7'b1_0011_1_0;
    localparam logic [6:0] CTL_UP  = 7'b1_1111_1_0;
    localparam logic [25:0] PINS_RESET = {3'b000, 16'h0000, 7'b0_1111_0_0};

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic            cmd_v_i = 1'b0;
    logic [25:0]     cmd_data_i = '0;
    logic            cmd_yumi_o;
    logic            wr_v_i = 1'b0;
    logic [WRW-1:0]  wr_data_i = '0;
    logic            wr_yumi_o;
    logic            rd_v_o;
    logic [RDW-1:0]  rd_data_o;
    logic            rd_ready_i = 1'b1;
    logic [2:0]      dfi_bank_o;
    logic [15:0]     dfi_address_o;
    logic            dfi_cke_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o;
    logic            dfi_we_n_o, dfi_reset_n_o, dfi_odt_o;
    logic            dfi_wrdata_en_o;
    logic [RDW-1:0]  dfi_wrdata_o;
    logic [2*GRP-1:0] dfi_wrdata_mask_o;
    logic            dfi_rddata_en_o;
    logic [RDW-1:0]  dfi_rddata_i = '0;
    logic            dfi_rddata_valid_i = 1'b0;
    logic            error_o;

    bsg_fifo_to_dfi #(
        .dq_data_width_p (DQ),
        .wr_latency_p    (WL),
        .rd_latency_p    (RL),
        .burst_cycles_p  (BC),
        .rd_fifo_els_p   (ELS)
    ) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .cmd_v_i            (cmd_v_i),
        .cmd_data_i         (cmd_data_i),
        .cmd_yumi_o         (cmd_yumi_o),
        .wr_v_i             (wr_v_i),
        .wr_data_i          (wr_data_i),
        .wr_yumi_o          (wr_yumi_o),
        .rd_v_o             (rd_v_o),
        .rd_data_o          (rd_data_o),
        .rd_ready_i         (rd_ready_i),
        .dfi_bank_o         (dfi_bank_o),
        .dfi_address_o      (dfi_address_o),
        .dfi_cke_o          (dfi_cke_o),
        .dfi_cs_n_o         (dfi_cs_n_o),
        .dfi_ras_n_o        (dfi_ras_n_o),
        .dfi_cas_n_o        (dfi_cas_n_o),
        .dfi_we_n_o         (dfi_we_n_o),
        .dfi_reset_n_o      (dfi_reset_n_o),
        .dfi_odt_o          (dfi_odt_o),
        .dfi_wrdata_en_o    (dfi_wrdata_en_o),
        .dfi_wrdata_o       (dfi_wrdata_o),
        .dfi_wrdata_mask_o  (dfi_wrdata_mask_o),
        .dfi_rddata_en_o    (dfi_rddata_en_o),
        .dfi_rddata_i       (dfi_rddata_i),
        .dfi_rddata_valid_i (dfi_rddata_valid_i),
        .error_o            (error_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { int cyc; logic [25:0] pkt; } cmd_exp_t;
    typedef struct { int cyc; logic [WRW-1:0] d; } wr_exp_t;

    cmd_exp_t       cmd_q[$];
    wr_exp_t        wr_q[$];
    int             rden_q[$];
    logic [RDW-1:0] rdout_q[$];
    int             ret_t[$];
    logic [RDW-1:0] ret_d[$];
    int             wr_pull_q[$];
    logic [25:0]    stim_q[$];

    int  last_cas = -1000;
    int  reserved = 0;
    int  occ = 0;
    bit  exp_err = 0;
    bit  acc_cmd = 0;
    bit  acc_wr = 0;
    bit  gaps = 0;
    bit  wr_off = 0;
    bit  force_valid = 0;
    bit  rand_ready = 0;
    logic [WRW-1:0] wr_word = '0;
    logic [25:0]    held = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic miss(input string name, input int exp_cyc);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d expected_cyc=%0d", name, cyc, exp_cyc);
    endtask

    function automatic logic [25:0] pkt(input logic [2:0] b, input logic [15:0] a, input logic [6:0] ctl);
        return {b, a, ctl};
    endfunction

    // Reference model: decides acceptance from timestamps and occupancy counts.
    always @(negedge clk_i) begin : model
        logic [25:0] p;
        bit is_cas, is_wr, is_rd, ok, pull, deq;
        if (reset_i) begin
            last_cas = -1000; reserved = 0; occ = 0; exp_err = 0;
            acc_cmd = 0; acc_wr = 0;
            cmd_q.delete(); wr_q.delete(); rden_q.delete(); rdout_q.delete();
            ret_t.delete(); ret_d.delete(); wr_pull_q.delete();
        end else begin
            chk("error_o", error_o, exp_err);
            chk("rd_v_o", rd_v_o, occ > 0);
            p      = cmd_data_i;
            is_cas = !p[5] && p[4] && !p[3];
            is_wr  = is_cas && !p[2];
            is_rd  = is_cas && p[2];
            ok = 1;
            if (is_cas && (cyc - last_cas < BC)) ok = 0;
            if (is_rd && (ELS - occ - reserved < BC)) ok = 0;
            acc_cmd = cmd_v_i && ok;
            chk("cmd_yumi", cmd_yumi_o, acc_cmd);

            pull = wr_pull_q.size() > 0 && wr_pull_q[0] == cyc;
            if (pull) void'(wr_pull_q.pop_front());
            acc_wr = pull && wr_v_i;
            chk("wr_yumi", wr_yumi_o, acc_wr);
            if (pull) begin
                wr_q.push_back('{cyc + 1, wr_v_i ? wr_data_i : '0});
                if (!wr_v_i) exp_err = 1;
            end

            deq = (occ > 0) && rd_ready_i;
            if (dfi_rddata_valid_i) begin
                if (reserved > 0) begin
                    reserved--; occ++;
                    rdout_q.push_back(dfi_rddata_i);
                end else begin
                    exp_err = 1;
                end
            end
            if (deq) occ--;

            if (acc_cmd) begin
                cmd_q.push_back('{cyc + 1, p});
                if (is_wr) begin
                    last_cas = cyc;
                    for (int k = 0; k < BC; k++) wr_pull_q.push_back(cyc + WL + k);
                end
                if (is_rd) begin
                    last_cas = cyc;
                    reserved += BC;
                    for (int k = 0; k < BC; k++) begin
                        rden_q.push_back(cyc + 1 + RL + k);
                        ret_t.push_back(cyc + 1 + RL + k + PHY_LAT);
                        ret_d.push_back({$urandom, $urandom});
                    end
                end
            end
        end
    end

    always @(negedge clk_i) begin : mon_cmd
        logic [25:0] pins, expv;
        pins = {dfi_bank_o, dfi_address_o, dfi_cke_o, dfi_cs_n_o, dfi_ras_n_o,
                dfi_cas_n_o, dfi_we_n_o, dfi_reset_n_o, dfi_odt_o};
        if (reset_i) begin
            held = PINS_RESET;
        end else begin
            if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
                expv = cmd_q[0].pkt;
                void'(cmd_q.pop_front());
                held = expv;
            end else begin
                expv = {held[25:6], 4'b1111, held[1:0]};
            end
            chk("dfi_cmd", pins, expv);
        end
    end

    always @(negedge clk_i) begin : mon_wr
        if (!reset_i) begin
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                miss("wrdata_en_missing", wr_q[0].cyc);
                void'(wr_q.pop_front());
            end
            if (dfi_wrdata_en_o) begin
                if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                    chk("wrdata", {dfi_wrdata_o, dfi_wrdata_mask_o}, wr_q[0].d);
                    void'(wr_q.pop_front());
                end else begin
                    miss("wrdata_en_unexpected", cyc);
                end
            end
        end
    end

    always @(negedge clk_i) begin : mon_rden
        if (!reset_i) begin
            while (rden_q.size() > 0 && rden_q[0] < cyc) begin
                miss("rddata_en_missing", rden_q[0]);
                void'(rden_q.pop_front());
            end
            if (dfi_rddata_en_o) begin
                if (rden_q.size() > 0 && rden_q[0] == cyc) begin
                    chk("rddata_en", dfi_rddata_en_o, 1'b1);
                    void'(rden_q.pop_front());
                end else begin
                    miss("rddata_en_unexpected", cyc);
                end
            end
        end
    end

    always @(negedge clk_i) begin : mon_rd
        if (!reset_i && rd_v_o && rd_ready_i) begin
            if (rdout_q.size() > 0) begin
                chk("rd_data", rd_data_o, rdout_q[0]);
                void'(rdout_q.pop_front());
            end else begin
                miss("rd_v_unexpected", cyc);
            end
        end
    end

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            if (acc_cmd && stim_q.size() > 0) void'(stim_q.pop_front());
            if (acc_wr) wr_word = {$urandom, $urandom, 8'($urandom)};
            if (rand_ready) rd_ready_i = 1'($urandom_range(0, 1));
            cmd_v_i = 1'b0;
            if (stim_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                cmd_v_i    = 1'b1;
                cmd_data_i = stim_q[0];
            end
            wr_v_i    = !wr_off;
            wr_data_i = wr_word;
            dfi_rddata_valid_i = 1'b0;
            if (ret_t.size() > 0 && ret_t[0] == cyc) begin
                dfi_rddata_valid_i = 1'b1;
                dfi_rddata_i       = ret_d[0];
                void'(ret_t.pop_front());
                void'(ret_d.pop_front());
            end
            if (force_valid) begin
                dfi_rddata_valid_i = 1'b1;
                dfi_rddata_i       = {$urandom, $urandom};
                force_valid        = 0;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || wr_q.size() > 0 || rden_q.size() > 0 || rdout_q.size() > 0
                || ret_t.size() > 0 || wr_pull_q.size() > 0 || occ > 0) && n < budget) begin
            run(1);
            n++;
        end
        chk("drain_left", stim_q.size() + wr_q.size() + rden_q.size() + rdout_q.size() + occ, 0);
    endtask

    initial begin
        logic [6:0] ctl;
        wr_word = {$urandom, $urandom, 8'($urandom)};
        reset_i = 1'b1;
        run(3);
        reset_i = 1'b0;
        run(20);

        stim_q.push_back(pkt(3'd0, 16'h0000, CTL_UP));
        run(5);
        stim_q.push_back(pkt(3'd3, 16'h0040, CTL_WR));
        run(15);
        stim_q.push_back(pkt(3'd1, 16'h0100, CTL_RD));
        stim_q.push_back(pkt(3'd2, 16'h0200, CTL_RD));
        run(30);

        rd_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) stim_q.push_back(pkt(3'(i), 16'(i * 8), CTL_RD));
        run(40);
        rd_ready_i = 1'b1;
        drain(200);

        gaps = 1; rand_ready = 1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ctl = CTL_RD;
                4, 5, 6, 7: ctl = CTL_WR;
                8:          ctl = CTL_ACT;
                default:    ctl = {CTL_UP[6:1], 1'($urandom_range(0, 1))};
            endcase
            stim_q.push_back(pkt(3'($urandom), 16'($urandom), ctl));
        end
        drain(3000);
        rand_ready = 0; gaps = 0; rd_ready_i = 1'b1;
        drain(200);

        wr_off = 1;
        stim_q.push_back(pkt(3'd5, 16'h0abc, CTL_WR));
        stim_q.push_back(pkt(3'd6, 16'h0def, CTL_RD));
        run(12);
        reset_i = 1'b1;
        stim_q.delete();
        wr_off = 0;
        run(2);
        reset_i = 1'b0;
        run(5);
        force_valid = 1;
        run(8);
        stim_q.push_back(pkt(3'd7, 16'h1234, CTL_RD));
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
